// File: rtl/alu_4bit_if.sv
// Operand/result bundle for alu_4bit: the master issues operations, the slave (the ALU)
// returns the registered result and flags.
interface alu_4bit_if;
   logic       in_valid;
   logic [3:0] a;
   logic [3:0] b;
   logic [1:0] sel;
   logic       out_valid;
   logic [4:0] result;
   logic       zero;
   logic       ovf;

   modport master (
      output in_valid, a, b, sel,
      input  out_valid, result, zero, ovf
   );

   modport slave (
      input  in_valid, a, b, sel,
      output out_valid, result, zero, ovf
   );
endinterface

// File: rtl/alu_4bit.sv
// Registered 4-bit ALU (AND/OR/ADD/SUB) with a 5-bit result and one-cycle latency.
// Define ALU4_FLAGS_EN to build the zero/ovf flag logic; otherwise both flags are tied low.
module alu_4bit (
   input  logic      clk,
   input  logic      rst,
   alu_4bit_if.slave bus
);

   logic [4:0] sum_s;
   logic [4:0] diff_s;
   logic [4:0] op_s;
   logic [4:0] result_d;
   logic [4:0] result_q;
   logic       valid_q;

   assign sum_s  = {1'b0, bus.a} + {1'b0, bus.b};
   assign diff_s = {1'b0, bus.a} - {1'b0, bus.b};

   // Combinational datapath selected by the opcode.
   always_comb begin
      op_s = 5'b00000;
      case (bus.sel)
         2'b00:   op_s = {1'b0, bus.a & bus.b};
         2'b01:   op_s = {1'b0, bus.a | bus.b};
         2'b10:   op_s = sum_s;
         2'b11:   op_s = diff_s;
         default: op_s = 5'b00000;
      endcase
   end

   // Output stage only moves when an operation is accepted.
   always_comb begin
      result_d = result_q;
      if (bus.in_valid) begin
         result_d = op_s;
      end else begin
         result_d = result_q;
      end
   end

   // Result register and the one-cycle valid pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= 5'b00000;
         valid_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         valid_q  <= bus.in_valid;
      end
   end

   assign bus.result    = result_q;
   assign bus.out_valid = valid_q;

`ifdef ALU4_FLAGS_EN
   logic zero_d;
   logic zero_q;
   logic ovf_d;
   logic ovf_q;

   // Flags follow the same accept/hold rule as the result; overflow treats operands as signed.
   always_comb begin
      zero_d = zero_q;
      ovf_d  = ovf_q;
      if (bus.in_valid) begin
         zero_d = (op_s == 5'b00000);
         case (bus.sel)
            2'b10:   ovf_d = (bus.a[3] == bus.b[3]) && (sum_s[3] != bus.a[3]);
            2'b11:   ovf_d = (bus.a[3] != bus.b[3]) && (diff_s[3] != bus.a[3]);
            default: ovf_d = 1'b0;
         endcase
      end else begin
         zero_d = zero_q;
         ovf_d  = ovf_q;
      end
   end

   // Flag registers; a reset result of zero reports zero=1.
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_q <= 1'b1;
         ovf_q  <= 1'b0;
      end else begin
         zero_q <= zero_d;
         ovf_q  <= ovf_d;
      end
   end

   assign bus.zero = zero_q;
   assign bus.ovf  = ovf_q;
`else
   assign bus.zero = 1'b0;
   assign bus.ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_4bit.sv
// Directed bench for alu_4bit: the driver queues hand-computed expectations,
// a monitor pops and compares them whenever out_valid is seen.
`timescale 1ns/1ps
module tb_alu_4bit;

`ifdef ALU4_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   typedef struct packed {
      logic [4:0] res;
      logic       z;
      logic       o;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   exp_t sb_q[$];

   alu_4bit_if bus ();

   alu_4bit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Expected flags collapse to 0 when the flag logic is not built.
   task automatic issue(input logic [1:0] s, input logic [3:0] av, input logic [3:0] bv,
                        input logic [4:0] r, input logic z, input logic o);
      exp_t e;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.sel      = s;
      bus.a        = av;
      bus.b        = bv;
      e.res = r;
      e.z   = z & FLAGS;
      e.o   = o & FLAGS;
      sb_q.push_back(e);
   endtask

   task automatic idle_check(input logic [4:0] held);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.sel      = 2'($urandom_range(0, 3));
      bus.a        = 4'($urandom_range(0, 15));
      bus.b        = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      check("idle_out_valid", {4'b0000, bus.out_valid}, 5'b00000);
      check("idle_result_held", bus.result, held);
   endtask

   // Monitor: every out_valid pulse must match the oldest queued expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (bus.out_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got result %b with no pending operation", bus.result);
         end else begin
            e = sb_q.pop_front();
            check("result", bus.result, e.res);
            check("zero", {4'b0000, bus.zero}, {4'b0000, e.z});
            check("ovf", {4'b0000, bus.ovf}, {4'b0000, e.o});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.sel      = 2'b00;
      bus.a        = 4'b0000;
      bus.b        = 4'b0000;
      rst          = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_result", bus.result, 5'b00000);
      check("reset_zero", {4'b0000, bus.zero}, {4'b0000, FLAGS});
      check("reset_ovf", {4'b0000, bus.ovf}, 5'b00000);
      check("reset_out_valid", {4'b0000, bus.out_valid}, 5'b00000);
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back stream covering every opcode.
      issue(2'b00, 4'b1100, 4'b1010, 5'b01000, 1'b0, 1'b0);
      issue(2'b00, 4'b1111, 4'b0000, 5'b00000, 1'b1, 1'b0);
      issue(2'b01, 4'b1100, 4'b1010, 5'b01110, 1'b0, 1'b0);
      issue(2'b01, 4'b1111, 4'b0000, 5'b01111, 1'b0, 1'b0);
      issue(2'b10, 4'b0011, 4'b0101, 5'b01000, 1'b0, 1'b1);
      issue(2'b10, 4'b1111, 4'b0001, 5'b10000, 1'b0, 1'b0);
      issue(2'b11, 4'b1000, 4'b0011, 5'b00101, 1'b0, 1'b1);
      issue(2'b11, 4'b0101, 4'b0101, 5'b00000, 1'b1, 1'b0);
      issue(2'b11, 4'b0001, 4'b0010, 5'b11111, 1'b0, 1'b0);
      idle_check(5'b11111);
      idle_check(5'b11111);

      // Reset coincident with in_valid drops the operation.
      @(negedge clk);
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.sel      = 2'b10;
      bus.a        = 4'b0011;
      bus.b        = 4'b0101;
      @(posedge clk);
      #1;
      check("rst_drop_result", bus.result, 5'b00000);
      check("rst_drop_zero", {4'b0000, bus.zero}, {4'b0000, FLAGS});
      check("rst_drop_out_valid", {4'b0000, bus.out_valid}, 5'b00000);
      @(negedge clk);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      issue(2'b11, 4'b0001, 4'b0010, 5'b11111, 1'b0, 1'b0);
      idle_check(5'b11111);

      repeat (2) @(posedge clk);
      #2;
      check("scoreboard_drained", 5'(sb_q.size()), 5'b00000);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
